// File: rtl/mem_req_ctrl.sv
// Dual-lane initiator for the dual-port data memory: issues registered strobes,
// serialises same-address hazards (lane 1 first) and returns per-lane responses.
module mem_req_ctrl #(
  parameter int unsigned       DW        = 32,
  parameter logic [DW-1:0]     BASE_ADDR = 32'h1000_0000,
  parameter int unsigned       NUM_WORDS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid_1,
  input  logic          req_we_1,
  input  logic [DW-1:0] req_addr_1,
  input  logic [DW-1:0] req_wdata_1,
  input  logic          req_valid_2,
  input  logic          req_we_2,
  input  logic [DW-1:0] req_addr_2,
  input  logic [DW-1:0] req_wdata_2,
  output logic          req_ready,
  output logic          stall,
  output logic          Mem_rd_1,
  output logic          Mem_wr_1,
  output logic [DW-1:0] Dir_Mem_1,
  output logic [DW-1:0] Dato_Mem_in_1,
  input  logic [DW-1:0] Dato_Mem_out_1,
  output logic          Mem_rd_2,
  output logic          Mem_wr_2,
  output logic [DW-1:0] Dir_Mem_2,
  output logic [DW-1:0] Dato_Mem_in_2,
  input  logic [DW-1:0] Dato_Mem_out_2,
  output logic          rsp_valid_1,
  output logic          rsp_err_1,
  output logic [DW-1:0] rsp_data_1,
  output logic          rsp_valid_2,
  output logic          rsp_err_2,
  output logic [DW-1:0] rsp_data_2
);

  typedef enum logic [2:0] {StIdle, StAcc, StSer1, StSer2, StRsp} state_e;

  typedef struct packed {
    logic          v;
    logic          we;
    logic          ok;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
  } lane_t;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [DW-1:0] dir;
    logic [DW-1:0] din;
  } port_t;

  typedef struct packed {
    logic          valid;
    logic          err;
    logic [DW-1:0] data;
  } rsp_t;

  localparam logic [DW-1:0] WinBytes = DW'(4 * NUM_WORDS);
  localparam port_t PortIdle = '{rd: 1'b1, wr: 1'b1, dir: '0, din: '0};

  function automatic logic is_legal(input logic [DW-1:0] a);
    return (a >= BASE_ADDR) && (a < BASE_ADDR + WinBytes) && (a[1:0] == 2'b00);
  endfunction

  // Illegal or absent lanes leave their port idle.
  function automatic port_t drive(input lane_t l);
    port_t p;
    p = PortIdle;
    if (l.v && l.ok) begin
      p.rd  = l.we;
      p.wr  = ~l.we;
      p.dir = l.addr;
      p.din = l.we ? l.wdata : '0;
    end
    return p;
  endfunction

  function automatic rsp_t respond(input lane_t l, input logic [DW-1:0] rdata);
    rsp_t r;
    r.valid = l.v;
    r.err   = l.v & ~l.ok;
    r.data  = (l.v && l.ok && !l.we) ? rdata : '0;
    return r;
  endfunction

  state_e        state_q, state_d;
  lane_t         lane1_q, lane1_d, lane2_q, lane2_d;
  lane_t         in1, in2;
  port_t         port1_q, port1_d, port2_q, port2_d;
  rsp_t          rsp1_q, rsp1_d, rsp2_q, rsp2_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          hazard;

  always_comb begin
    in1 = '{v: req_valid_1, we: req_we_1, ok: is_legal(req_addr_1),
            addr: req_addr_1, wdata: req_wdata_1};
    in2 = '{v: req_valid_2, we: req_we_2, ok: is_legal(req_addr_2),
            addr: req_addr_2, wdata: req_wdata_2};
    hazard = in1.v && in2.v && in1.ok && in2.ok && (in1.addr == in2.addr) &&
             (in1.we || in2.we);
  end

  always_comb begin
    state_d = state_q;
    lane1_d = lane1_q;
    lane2_d = lane2_q;
    port1_d = PortIdle;
    port2_d = PortIdle;
    rsp1_d  = '0;
    rsp2_d  = '0;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_1 || req_valid_2) begin
          lane1_d = in1;
          lane2_d = in2;
          port1_d = drive(in1);
          if (hazard) begin
            state_d = StSer1;
          end else begin
            state_d = StAcc;
            port2_d = drive(in2);
          end
        end
      end
      StAcc: begin
        state_d = StRsp;
        rsp1_d  = respond(lane1_q, Dato_Mem_out_1);
        rsp2_d  = respond(lane2_q, Dato_Mem_out_2);
      end
      StSer1: begin
        state_d = StSer2;
        hold_d  = Dato_Mem_out_1;
        port2_d = drive(lane2_q);
      end
      StSer2: begin
        state_d = StRsp;
        rsp1_d  = respond(lane1_q, hold_q);
        rsp2_d  = respond(lane2_q, Dato_Mem_out_2);
      end
      StRsp:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lane1_q <= '0;
      lane2_q <= '0;
      port1_q <= PortIdle;
      port2_q <= PortIdle;
      rsp1_q  <= '0;
      rsp2_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      lane1_q <= lane1_d;
      lane2_q <= lane2_d;
      port1_q <= port1_d;
      port2_q <= port2_d;
      rsp1_q  <= rsp1_d;
      rsp2_q  <= rsp2_d;
      hold_q  <= hold_d;
    end
  end

  assign req_ready     = (state_q == StIdle);
  assign stall         = ~req_ready;
  assign Mem_rd_1      = port1_q.rd;
  assign Mem_wr_1      = port1_q.wr;
  assign Dir_Mem_1     = port1_q.dir;
  assign Dato_Mem_in_1 = port1_q.din;
  assign Mem_rd_2      = port2_q.rd;
  assign Mem_wr_2      = port2_q.wr;
  assign Dir_Mem_2     = port2_q.dir;
  assign Dato_Mem_in_2 = port2_q.din;
  assign rsp_valid_1   = rsp1_q.valid;
  assign rsp_err_1     = rsp1_q.err;
  assign rsp_data_1    = rsp1_q.data;
  assign rsp_valid_2   = rsp2_q.valid;
  assign rsp_err_2     = rsp2_q.err;
  assign rsp_data_2    = rsp2_q.data;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: directed table, reset/back-to-back sequences and
// randomized transactions checked against a transaction-level memory model.
module tb_mem_req_ctrl;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk, rst;
  logic        req_valid_1, req_we_1, req_valid_2, req_we_2;
  logic [31:0] req_addr_1, req_wdata_1, req_addr_2, req_wdata_2;
  logic        req_ready, stall;
  logic        Mem_rd_1, Mem_wr_1, Mem_rd_2, Mem_wr_2;
  logic [31:0] Dir_Mem_1, Dato_Mem_in_1, Dato_Mem_out_1;
  logic [31:0] Dir_Mem_2, Dato_Mem_in_2, Dato_Mem_out_2;
  logic        rsp_valid_1, rsp_err_1, rsp_valid_2, rsp_err_2;
  logic [31:0] rsp_data_1, rsp_data_2;

  int n_cmp = 0;
  int n_bad = 0;

  mem_req_ctrl #(.DW(32), .BASE_ADDR(BASE), .NUM_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid_1(req_valid_1), .req_we_1(req_we_1), .req_addr_1(req_addr_1),
    .req_wdata_1(req_wdata_1),
    .req_valid_2(req_valid_2), .req_we_2(req_we_2), .req_addr_2(req_addr_2),
    .req_wdata_2(req_wdata_2),
    .req_ready(req_ready), .stall(stall),
    .Mem_rd_1(Mem_rd_1), .Mem_wr_1(Mem_wr_1), .Dir_Mem_1(Dir_Mem_1),
    .Dato_Mem_in_1(Dato_Mem_in_1), .Dato_Mem_out_1(Dato_Mem_out_1),
    .Mem_rd_2(Mem_rd_2), .Mem_wr_2(Mem_wr_2), .Dir_Mem_2(Dir_Mem_2),
    .Dato_Mem_in_2(Dato_Mem_in_2), .Dato_Mem_out_2(Dato_Mem_out_2),
    .rsp_valid_1(rsp_valid_1), .rsp_err_1(rsp_err_1), .rsp_data_1(rsp_data_1),
    .rsp_valid_2(rsp_valid_2), .rsp_err_2(rsp_err_2), .rsp_data_2(rsp_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic legal(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd16) && (a[1:0] == 2'b00);
  endfunction

  // Dual-port memory environment: combinational read, write on strobe edge.
  logic [31:0] mem [4];
  logic        mem_init;
  assign Dato_Mem_out_1 = legal(Dir_Mem_1) ? mem[Dir_Mem_1[3:2]] : 32'h0;
  assign Dato_Mem_out_2 = legal(Dir_Mem_2) ? mem[Dir_Mem_2[3:2]] : 32'h0;
  always @(posedge clk) begin
    if (mem_init) begin
      mem[0] <= 32'h8; mem[1] <= 32'hD; mem[2] <= 32'h2; mem[3] <= 32'h10;
    end else begin
      if (!Mem_wr_1 && legal(Dir_Mem_1)) mem[Dir_Mem_1[3:2]] <= Dato_Mem_in_1;
      if (!Mem_wr_2 && legal(Dir_Mem_2)) mem[Dir_Mem_2[3:2]] <= Dato_Mem_in_2;
    end
  end

  typedef struct packed {
    logic        v1, we1;
    logic [31:0] a1, wd1;
    logic        v2, we2;
    logic [31:0] a2, wd2;
    logic [3:0]  lat;
    logic [31:0] d1, d2;
    logic        e1, e2;
    logic [3:0]  s1, s2;  // {rd1,wr1,rd2,wr2} in first and second busy cycle
  } vec_t;

  logic [31:0] mdl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Transaction-level reference: lane 1 fully completes before lane 2.
  task automatic model(input vec_t r, output vec_t e);
    logic l1, l2, hz;
    logic [1:0] c1, c2;
    e  = r;
    l1 = legal(r.a1);
    l2 = legal(r.a2);
    hz = r.v1 && r.v2 && l1 && l2 && (r.a1 == r.a2) && (r.we1 || r.we2);
    e.lat = hz ? 4'd3 : 4'd2;
    e.e1 = r.v1 && !l1;
    e.e2 = r.v2 && !l2;
    e.d1 = 0;
    e.d2 = 0;
    if (r.v1 && l1) begin
      if (r.we1) mdl[r.a1[3:2]] = r.wd1; else e.d1 = mdl[r.a1[3:2]];
    end
    if (r.v2 && l2) begin
      if (r.we2) mdl[r.a2[3:2]] = r.wd2; else e.d2 = mdl[r.a2[3:2]];
    end
    c1 = !(r.v1 && l1) ? 2'b11 : (r.we1 ? 2'b10 : 2'b01);
    c2 = !(r.v2 && l2) ? 2'b11 : (r.we2 ? 2'b10 : 2'b01);
    e.s1 = hz ? {c1, 2'b11} : {c1, c2};
    e.s2 = hz ? {2'b11, c2} : 4'b1111;
  endtask

  task automatic run(input vec_t v, input string tag);
    int lat = -1;
    logic [3:0] s1, s2;
    logic st1, st2, rv1, rv2, re1, re2;
    logic [31:0] dir1, rd1, rd2;
    {s2, st2, rv1, rv2, re1, re2, rd1, rd2} = '0;
    @(negedge clk);
    req_valid_1 = v.v1; req_we_1 = v.we1; req_addr_1 = v.a1; req_wdata_1 = v.wd1;
    req_valid_2 = v.v2; req_we_2 = v.we2; req_addr_2 = v.a2; req_wdata_2 = v.wd2;
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid_1 = 1'b0; req_valid_2 = 1'b0;
    s1 = {Mem_rd_1, Mem_wr_1, Mem_rd_2, Mem_wr_2};
    st1 = stall; dir1 = Dir_Mem_1;
    for (int k = 2; k <= 6 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 2) begin s2 = {Mem_rd_1, Mem_wr_1, Mem_rd_2, Mem_wr_2}; st2 = stall; end
      if (rsp_valid_1 || rsp_valid_2) begin
        lat = k;
        {rv1, rv2, re1, re2, rd1, rd2} =
          {rsp_valid_1, rsp_valid_2, rsp_err_1, rsp_err_2, rsp_data_1, rsp_data_2};
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'(v.lat));
    chk({tag, " strobes1"}, 32'(s1), 32'(v.s1));
    chk({tag, " strobes2"}, 32'(s2), 32'(v.s2));
    chk({tag, " dir1"}, dir1, (v.s1[3:2] != 2'b11) ? v.a1 : 32'h0);
    chk({tag, " stall"}, {st1, st2}, 2'b11);
    chk({tag, " rsp_valid"}, {rv1, rv2}, {v.v1, v.v2});
    chk({tag, " rsp_err"}, {re1, re2}, {v.e1, v.e2});
    chk({tag, " rsp_data_1"}, rd1, v.d1);
    chk({tag, " rsp_data_2"}, rd2, v.d2);
    @(negedge clk);
    chk({tag, " post"}, {rsp_valid_1, rsp_valid_2, req_ready, stall}, 4'b0010);
  endtask

  vec_t tbl [4];
  vec_t r, e;
  logic [11:0] rdy_pat, rsp_pat;
  int bad_cnt;

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0: return BASE + 32'd16;
      1: return BASE + 32'(4 * $urandom_range(0, 3) + $urandom_range(1, 3));
      2: return BASE - 32'd4;
      default: return BASE + 32'(4 * $urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    {req_valid_1, req_we_1, req_addr_1, req_wdata_1} = '0;
    {req_valid_2, req_we_2, req_addr_2, req_wdata_2} = '0;
    mdl[0] = 32'h8; mdl[1] = 32'hD; mdl[2] = 32'h2; mdl[3] = 32'h10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; mem_init = 1'b0;

    chk("reset strobes", {Mem_rd_1, Mem_wr_1, Mem_rd_2, Mem_wr_2}, 4'b1111);
    chk("reset addr/data", Dir_Mem_1 | Dir_Mem_2 | Dato_Mem_in_1 | Dato_Mem_in_2, 0);
    chk("reset rsp_data", rsp_data_1 | rsp_data_2, 0);
    chk("reset flags", {rsp_valid_1, rsp_err_1, rsp_valid_2, rsp_err_2, stall, req_ready},
        6'b000001);

    tbl[0] = '{v1: 1, a1: BASE + 4, v2: 1, a2: BASE + 12, lat: 2, d1: 32'hD, d2: 32'h10,
               s1: 4'b0101, s2: 4'b1111, default: 0};
    tbl[1] = '{v1: 1, we1: 1, a1: BASE + 8, wd1: 32'hAA, v2: 1, a2: BASE + 8, lat: 3,
               d2: 32'hAA, s1: 4'b1011, s2: 4'b1101, default: 0};
    tbl[2] = '{v1: 1, a1: BASE + 16, v2: 1, a2: BASE + 1, lat: 2, e1: 1, e2: 1,
               s1: 4'b1111, s2: 4'b1111, default: 0};
    tbl[3] = '{v1: 1, a1: BASE, v2: 1, a2: BASE, lat: 2, d1: 32'h8, d2: 32'h8,
               s1: 4'b0101, s2: 4'b1111, default: 0};
    for (int i = 0; i < 4; i++) begin
      model(tbl[i], e);  // keeps the reference memory in step
      run(tbl[i], $sformatf("dir%0d", i));
    end

    // Reset while lane 1 store is strobing in SER1; that store still lands.
    @(negedge clk);
    req_valid_1 = 1; req_we_1 = 1; req_addr_1 = BASE + 12; req_wdata_1 = 32'h55;
    req_valid_2 = 1; req_we_2 = 0; req_addr_2 = BASE + 12;
    @(negedge clk);
    req_valid_1 = 0; req_valid_2 = 0;
    chk("rst ser1 strobes", {Mem_rd_1, Mem_wr_1, Mem_rd_2, Mem_wr_2}, 4'b1011);
    rst = 1'b1;
    mdl[3] = 32'h55;
    @(negedge clk);
    rst = 1'b0;
    chk("rst strobes", {Mem_rd_1, Mem_wr_1, Mem_rd_2, Mem_wr_2}, 4'b1111);
    chk("rst ready/stall", {req_ready, stall}, 2'b10);
    bad_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid_1 || rsp_valid_2 || !Mem_rd_1 || !Mem_wr_1 || !Mem_rd_2 || !Mem_wr_2)
        bad_cnt++;
      @(negedge clk);
    end
    chk("rst no rsp", 32'(bad_cnt), 0);

    // Requests held valid: accepted once every three cycles.
    req_valid_1 = 1; req_we_1 = 0; req_addr_1 = BASE;
    req_valid_2 = 1; req_we_2 = 0; req_addr_2 = BASE + 4;
    bad_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      rdy_pat[11-i] = req_ready;
      rsp_pat[11-i] = rsp_valid_1 && rsp_valid_2;
      if (stall !== !req_ready) bad_cnt++;
      if (rsp_valid_1 && (rsp_data_1 !== mdl[0] || rsp_data_2 !== mdl[1])) bad_cnt++;
    end
    req_valid_1 = 0; req_valid_2 = 0;
    chk("b2b ready pattern", 32'(rdy_pat), 32'(12'b100100100100));
    chk("b2b rsp pattern", 32'(rsp_pat), 32'(12'b001001001001));
    chk("b2b stall/data", 32'(bad_cnt), 0);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      r = '0;
      r.v1 = 1'($urandom_range(0, 1));
      r.v2 = 1'($urandom_range(0, 1));
      if (!r.v1 && !r.v2) r.v1 = 1'b1;
      r.we1 = 1'($urandom_range(0, 1));
      r.we2 = 1'($urandom_range(0, 1));
      r.a1 = rand_addr();
      r.a2 = ($urandom_range(0, 2) == 0) ? r.a1 : rand_addr();
      r.wd1 = $urandom;
      r.wd2 = $urandom;
      model(r, e);
      run(e, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Initiator side of the dual-port data memory interface in the superscalar core.
- Accepts one load/store request per lane per transaction from the two MEM-stage lanes.
- Drives the memory's active-low read/write strobes, address and write data, then returns read data to each lane with a valid pulse.
- Serialises same-address hazards between lanes (lane 1 first, then lane 2), rejects out-of-window addresses, and stalls the pipeline while busy.

Parameters:
- BASE_ADDR, 32'h10000000, first byte address of the data window.
- NUM_WORDS, 4, number of 32-bit words in the window.
- DW, 32, data and address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid_1  in  1  lane 1 request present
- req_we_1  in  1  lane 1 request type: 1 = store, 0 = load
- req_addr_1  in  DW  lane 1 byte address
- req_wdata_1  in  DW  lane 1 store data
- req_valid_2, req_we_2, req_addr_2, req_wdata_2  in  1/1/DW/DW  lane 2 equivalents
- req_ready  out  1  requests accepted this cycle
- stall  out  1  pipeline hold
- Mem_rd_1, Mem_wr_1  out  1  port 1 strobes, active low
- Dir_Mem_1, Dato_Mem_in_1  out  DW  port 1 address and write data
- Dato_Mem_out_1  in  DW  port 1 read data (combinational from memory)
- Mem_rd_2, Mem_wr_2, Dir_Mem_2, Dato_Mem_in_2, Dato_Mem_out_2  port 2 equivalents
- rsp_valid_1, rsp_err_1  out  1  lane 1 response pulse and error flag
- rsp_data_1  out  DW  lane 1 load data
- rsp_valid_2, rsp_err_2, rsp_data_2  lane 2 equivalents

Behaviour:
- Reset values:
  - All Mem_rd_x and Mem_wr_x = 1.
  - Dir_Mem_x, Dato_Mem_in_x, rsp_data_x = 0.
  - rsp_valid_x, rsp_err_x, stall = 0.
  - req_ready = 1.
  - State = IDLE.
- Reset mid-operation abandons any pending access: strobes are deasserted the next edge and no rsp_valid is issued.
- All memory-side outputs are registered. Strobes are never low outside a strobe cycle.
- At most one strobe is low per port per cycle.
- Address check: address is legal when BASE_ADDR <= addr < BASE_ADDR + 4*NUM_WORDS and addr[1:0] = 0.
  - An illegal lane is never strobed.
  - It receives rsp_valid = 1, rsp_err = 1, rsp_data = 0 in the same cycle its strobe would have completed.
- Hazard: both lanes valid, both legal, equal addresses, and at least one store.
- States:
  - IDLE: req_ready = 1. On any req_valid, capture both lanes.
    - No hazard: go to ACC.
    - Hazard: go to SER1.
    - No valid request: stay in IDLE.
  - ACC (1 cycle): strobe each valid, legal lane on its own port. Next: RSP.
  - SER1 (1 cycle): strobe lane 1 on port 1 only. Next: SER2.
  - SER2 (1 cycle): port 1 idle; strobe lane 2 on port 2. Next: RSP.
  - RSP (1 cycle): deassert all strobes; drive rsp_valid for each captured lane. Next: IDLE.
- Strobe encoding:
  - Load: Mem_rd_x = 0, Mem_wr_x = 1.
  - Store: Mem_rd_x = 1, Mem_wr_x = 0, with Dato_Mem_in_x = wdata.
- Read data is sampled at the end of each strobe cycle.
- Lane 1 load data in SER1 is held until RSP, so both lanes respond together in RSP.
- Store response: rsp_valid = 1, rsp_data = 0, rsp_err = 0.
- Latency from accept (IDLE edge) to rsp_valid:
  - Normal: 2 cycles.
  - Hazard: 3 cycles.
- rsp_valid_x is a single-cycle pulse. Lanes with no captured request get no pulse.
- Handshake outputs:
  - req_ready = (state == IDLE).
  - stall = ~req_ready.
  - Requests presented while req_ready = 0 are ignored; the pipeline must hold them.
- When a port is idle, Dir_Mem_x returns to 0.

Test Plan:
- Bench memory preload: 0x10000000 = 0x8, 0x10000004 = 0xD, 0x10000008 = 0x2, 0x1000000C = 0x10.
- Lane 1 load 0x10000004, lane 2 load 0x1000000C.
  - Required: ACC shows Mem_rd_1 = 0 and Mem_rd_2 = 0.
  - 2 cycles later: rsp_data_1 = 0xD, rsp_data_2 = 0x10, stall high for 2 cycles.
- Lane 1 store 0xAA to 0x10000008, lane 2 load 0x10000008 (hazard).
  - Required: SER1 shows only Mem_wr_1 = 0; SER2 shows only Mem_rd_2 = 0.
  - rsp_data_2 = 0xAA, 3-cycle latency.
- Lane 1 load 0x10000010, lane 2 load 0x10000001.
  - Required: no strobe goes low.
  - rsp_err_1 = 1, rsp_err_2 = 1, both rsp_data = 0.
- Both lanes load 0x10000000 (no store, so no hazard).
  - Required: parallel ACC, both rsp_data = 0x8.
- Assert rst during SER1.
  - Required: next cycle all strobes = 1, state IDLE, req_ready = 1, no rsp_valid.
- Back-to-back requests held on req_valid.
  - Required: a new accept every 3 cycles (IDLE, ACC, RSP).
  - Requests presented while stall = 1 are not accepted.
